// File: rtl/e203_nts_pkg.sv
// Shared definitions for the NTS interrupt context scheduler: group geometry,
// FSM encoding and the caller-saved register packing used by the regfile.
package e203_nts_pkg;

   localparam int NTS_GRP_NUM = 4;
   localparam int NTS_GRP_W   = 128;
   localparam int NTS_DEPTH   = 4;

   typedef enum logic [2:0] {
      NTS_IDLE,
      NTS_SAVE,
      NTS_RD_REQ,
      NTS_RD_WAIT,
      NTS_RD_WB
   } nts_state_e;

   // Architectural register index held in a given slot of a group:
   // G0={x1,x5,x6,x7}, G1=x10..x13, G2=x14..x17, G3=x28..x31.
   function automatic logic [4:0] grp_reg_idx(input logic [1:0] grp, input logic [1:0] slot);
      logic [4:0] idx;
      case (grp)
         2'd0:    idx = (slot == 2'd0) ? 5'd1 : 5'd4 + {3'd0, slot};
         2'd1:    idx = 5'd10 + {3'd0, slot};
         2'd2:    idx = 5'd14 + {3'd0, slot};
         default: idx = 5'd28 + {3'd0, slot};
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/e203_nts_ctx_sched.sv
// Interrupt context save/restore sequencer: walks the four caller-saved groups
// between the regfile and a context RAM, keeping a stack of nested contexts.
module e203_nts_ctx_sched
   import e203_nts_pkg::*;
#(
   parameter int GRP_W = NTS_GRP_W,
   parameter int DEPTH = NTS_DEPTH,
   parameter int LVL_W = $clog2(DEPTH),
   parameter int AW    = LVL_W + 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             save_req_i,
   input  logic             rest_req_i,
   output logic [1:0]       grp_sel_o,
   input  logic [GRP_W-1:0] grp_rdata_i,
   output logic             grp_we_o,
   output logic [GRP_W-1:0] grp_wdata_o,
   output logic             ram_req_o,
   output logic             ram_we_o,
   output logic [AW-1:0]    ram_addr_o,
   output logic [GRP_W-1:0] ram_wdata_o,
   input  logic             ram_gnt_i,
   input  logic             ram_rvalid_i,
   input  logic [GRP_W-1:0] ram_rdata_i,
   output logic             busy_o,
   output logic             save_done_o,
   output logic             rest_done_o,
   output logic [LVL_W:0]   depth_o,
   output logic             ovf_o,
   output logic             unf_o
);

   localparam logic [LVL_W:0] DEPTH_MAX = (LVL_W+1)'(DEPTH);
   localparam logic [1:0]     LAST_BEAT = 2'(NTS_GRP_NUM - 1);

   nts_state_e       r_state;
   logic             r_pend_save;
   logic             r_pend_rest;
   logic [LVL_W:0]   r_depth;
   logic [1:0]       r_beat;
   logic             r_save_done;
   logic             r_rest_done;
   logic             r_ovf;
   logic             r_unf;
   logic [GRP_W-1:0] r_grp_wdata;

   logic             w_take_save;
   logic             w_take_rest;
   logic [LVL_W-1:0] w_lvl_wr;
   logic [LVL_W-1:0] w_lvl_rd;

   // Save wins when both are pending; a refused op (ovf/unf) still consumes its flag.
   assign w_take_save = (r_state == NTS_IDLE) && r_pend_save;
   assign w_take_rest = (r_state == NTS_IDLE) && !r_pend_save && r_pend_rest;
   assign w_lvl_wr    = r_depth[LVL_W-1:0];
   assign w_lvl_rd    = r_depth[LVL_W-1:0] - LVL_W'(1);

   assign busy_o      = (r_state != NTS_IDLE);
   assign save_done_o = r_save_done;
   assign rest_done_o = r_rest_done;
   assign ovf_o       = r_ovf;
   assign unf_o       = r_unf;
   assign depth_o     = r_depth;
   assign grp_wdata_o = r_grp_wdata;

   always_comb begin
      ram_req_o   = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      grp_sel_o   = 2'd0;
      grp_we_o    = 1'b0;
      case (r_state)
         NTS_SAVE: begin
            ram_req_o   = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = {w_lvl_wr, r_beat};
            ram_wdata_o = grp_rdata_i;
            grp_sel_o   = r_beat;
         end
         NTS_RD_REQ: begin
            ram_req_o  = 1'b1;
            ram_addr_o = {w_lvl_rd, r_beat};
         end
         NTS_RD_WB: begin
            grp_we_o  = 1'b1;
            grp_sel_o = r_beat;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= NTS_IDLE;
         r_pend_save <= 1'b0;
         r_pend_rest <= 1'b0;
         r_depth     <= '0;
         r_beat      <= 2'd0;
         r_save_done <= 1'b0;
         r_rest_done <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_grp_wdata <= '0;
      end else begin
         r_save_done <= 1'b0;
         r_rest_done <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_pend_save <= w_take_save ? 1'b0 : (r_pend_save | save_req_i);
         r_pend_rest <= w_take_rest ? 1'b0 : (r_pend_rest | rest_req_i);
         case (r_state)
            NTS_IDLE: begin
               r_beat <= 2'd0;
               if (r_pend_save) begin
                  if (r_depth == DEPTH_MAX) r_ovf   <= 1'b1;
                  else                      r_state <= NTS_SAVE;
               end else if (r_pend_rest) begin
                  if (r_depth == '0) r_unf   <= 1'b1;
                  else               r_state <= NTS_RD_REQ;
               end
            end
            NTS_SAVE: begin
               if (ram_gnt_i) begin
                  r_beat <= r_beat + 2'd1;
                  if (r_beat == LAST_BEAT) begin
                     r_depth     <= r_depth + (LVL_W+1)'(1);
                     r_save_done <= 1'b1;
                     r_state     <= NTS_IDLE;
                  end
               end
            end
            NTS_RD_REQ: begin
               if (ram_gnt_i) begin
                  if (ram_rvalid_i) begin
                     r_grp_wdata <= ram_rdata_i;
                     r_state     <= NTS_RD_WB;
                  end else begin
                     r_state <= NTS_RD_WAIT;
                  end
               end
            end
            NTS_RD_WAIT: begin
               if (ram_rvalid_i) begin
                  r_grp_wdata <= ram_rdata_i;
                  r_state     <= NTS_RD_WB;
               end
            end
            NTS_RD_WB: begin
               if (r_beat == LAST_BEAT) begin
                  r_depth     <= r_depth - (LVL_W+1)'(1);
                  r_rest_done <= 1'b1;
                  r_state     <= NTS_IDLE;
               end else begin
                  r_beat  <= r_beat + 2'd1;
                  r_state <= NTS_RD_REQ;
               end
            end
            default: r_state <= NTS_IDLE;
         endcase
      end
   end

endmodule
